// File: rtl/alu_mul_sequencer.sv
// Shift-add unsigned multiplier that borrows the core ALU adder.
// One ADD/SHIFT pair per multiplier bit, fixed 2*WIDTH+1 cycle latency.
`ifndef FWIDTH
`define FWIDTH 4
`endif
`ifndef ALUCTLW
`define ALUCTLW 3
`endif
`ifndef CARRY_FLAG
`define CARRY_FLAG 0
`endif
`ifndef ZERO_FLAG
`define ZERO_FLAG 1
`endif
`ifndef NEG_FLAG
`define NEG_FLAG 2
`endif
`ifndef OVF_FLAG
`define OVF_FLAG 3
`endif

module alu_mul_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    multiplicand,
  input  logic [WIDTH-1:0]    multiplier,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    product_hi,
  output logic [WIDTH-1:0]    product_lo,
  output logic [`FWIDTH-1:0]  flags_out,
  output logic [WIDTH-1:0]    alu_op1,
  output logic [WIDTH-1:0]    alu_op2,
  output logic [`ALUCTLW-1:0] alu_ctl,
  output logic [`FWIDTH-1:0]  alu_flags_in,
  input  logic [WIDTH-1:0]    alu_result,
  input  logic [`FWIDTH-1:0]  alu_flags
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [`FWIDTH-1:0] CMASK =
    `FWIDTH'(1) << `CARRY_FLAG;

  state_t            state;
  state_t            state_nx;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  mcand;
  logic [CNTW-1:0]   cnt;
  logic              carry;
  logic              alu_c;
  logic              last;
  logic [`FWIDTH-1:0] flags_nx;

  // Only the carry bit of the ALU flags matters here
  assign alu_c = |(alu_flags & CMASK);
  assign last  = (cnt == CNTW'(WIDTH - 1));

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign alu_flags_in = '0;

  always_comb begin
    state_nx = state;
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctl  = '0;
    unique case (state)
      IDLE:  if (start) state_nx = ADD;
      ADD: begin
        alu_op1  = hi;
        alu_op2  = mcand;
        state_nx = SHIFT;
      end
      SHIFT: state_nx = last ? DONE : ADD;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    flags_nx = '0;
    flags_nx[`ZERO_FLAG] = ({hi, lo} == '0);
    flags_nx[`NEG_FLAG]  = hi[WIDTH-1];
    flags_nx[`OVF_FLAG]  = (hi != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hi         <= '0;
      lo         <= '0;
      mcand      <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
      flags_out  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= multiplicand;
            lo    <= multiplier;
            hi    <= '0;
            cnt   <= '0;
          end
        end
        ADD: begin
          if (lo[0]) begin
            hi    <= alu_result;
            carry <= alu_c;
          end else begin
            carry <= 1'b0;
          end
        end
        SHIFT: begin
          hi  <= {carry, hi[WIDTH-1:1]};
          lo  <= {hi[0], lo[WIDTH-1:1]};
          cnt <= cnt + CNTW'(1);
        end
        DONE: begin
          product_hi <= hi;
          product_lo <= lo;
          flags_out  <= flags_nx;
        end
        default: ;
      endcase
    end
  end

endmodule
